latency_pipe: RTL and testbench

Parametrised fixed-latency elastic pipeline with valid/ready handshake on both sides, used in `util` to line up a data path with a parallel compute path of known depth. It sustains one beat per cycle, collapses bubbles under backpressure, and adds a synchronous flush and an occupancy count. It sits between a producer and a consumer that both speak valid/ready.

---
 rtl/latency_pipe_pkg.sv | 20 ++
 rtl/latency_pipe_stage.sv | 54 +++++
 rtl/latency_pipe.sv | 97 +++++++++
 tb/tb_latency_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/latency_pipe_pkg.sv
// Shared definitions for latency_pipe: minimum legal depth and a width helper
// used to size the occupancy counter.
package latency_pipe_pkg;

  localparam int MIN_LATENCY = 1;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/latency_pipe_stage.sv
// One pipeline stage: data register plus valid bit. It loads on load, and
// clear drops the valid bit without touching the data.
module latency_pipe_stage
  import latency_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  v,
  output logic [DATA_WIDTH-1:0] d
);

  logic                  v_q;
  logic                  v_d;
  logic [DATA_WIDTH-1:0] d_q;
  logic [DATA_WIDTH-1:0] d_d;

  // A bubble load only clears the valid bit, so the data register holds still.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clear) begin
      v_d = 1'b0;
    end else if (load) begin
      v_d = src_valid;
      if (src_valid) begin
        d_d = src_data;
      end else begin
        d_d = d_q;
      end
    end else begin
      v_d = v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule

// File: rtl/latency_pipe.sv
// Fixed-latency elastic pipeline with valid/ready on both sides, bubble
// collapsing under backpressure, synchronous flush and an occupancy count.
module latency_pipe
  import latency_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 4,
  parameter int CNT_WIDTH  = clog2(LATENCY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  count
);

  if (LATENCY < MIN_LATENCY) begin : g_bad_latency
    $error("latency_pipe: LATENCY must be at least %0d", MIN_LATENCY);
  end

  logic [LATENCY-1:0]    en_s;
  logic [LATENCY-1:0]    v_s;
  logic [DATA_WIDTH-1:0] d_s [LATENCY];
  logic                  accept_s;
  logic                  deliver_s;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;

  // Ready ripples back from the output: a full stage can move only if the one ahead moves.
  always_comb begin
    en_s = '0;
    en_s[LATENCY-1] = !v_s[LATENCY-1] || out_ready;
    for (int i = LATENCY - 2; i >= 0; i--) begin
      en_s[i] = !v_s[i] || (v_s[i+1] ? en_s[i+1] : 1'b1);
    end
  end

  assign in_ready  = en_s[0] && !flush && !rst;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = v_s[LATENCY-1] && !flush;
  assign deliver_s = out_valid && out_ready;
  assign dout      = d_s[LATENCY-1];

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_head
      latency_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (en_s[g]),
        .clear     (flush),
        .src_valid (accept_s),
        .src_data  (din),
        .v         (v_s[g]),
        .d         (d_s[g])
      );
    end else begin : g_body
      latency_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (en_s[g]),
        .clear     (flush),
        .src_valid (v_s[g-1]),
        .src_data  (d_s[g-1]),
        .v         (v_s[g]),
        .d         (d_s[g])
      );
    end
  end

  // Occupancy tracks accept minus deliver; both together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({accept_s, deliver_s})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_latency_pipe.sv
// Directed checks of latency_pipe at LATENCY=4 plus a scoreboarded random run at LATENCY=1.
module tb_latency_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        flush4 = 1'b0;
  logic [7:0]  din4 = 8'h00;
  logic        iv4 = 1'b0;
  logic        ir4;
  logic [7:0]  dout4;
  logic        ov4;
  logic        or4 = 1'b0;
  logic [2:0]  cnt4;

  logic        flush1 = 1'b0;
  logic [31:0] din1 = 32'h0;
  logic        iv1 = 1'b0;
  logic        ir1;
  logic [31:0] dout1;
  logic        ov1;
  logic        or1 = 1'b0;
  logic [0:0]  cnt1;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  latency_pipe #(.DATA_WIDTH(8), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .din(din4), .in_valid(iv4),
    .in_ready(ir4), .dout(dout4), .out_valid(ov4), .out_ready(or4), .count(cnt4)
  );

  latency_pipe #(.DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .din(din1), .in_valid(iv1),
    .in_ready(ir1), .dout(dout1), .out_valid(ov1), .out_ready(or1), .count(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    @(negedge clk);
    chk("rst_in_ready", 32'(ir4), 32'd0);
    tick();
    @(negedge clk);
    chk("rst_count", 32'(cnt4), 32'd0);
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_dout", 32'(dout4), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(ir4), 32'd1);
    chk("post_rst_count", 32'(cnt4), 32'd0);
    tick();

    // Streaming 0x01..0x10 with out_ready held high
    or4 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      iv4  = (c < 16);
      din4 = 8'(c + 1);
      @(negedge clk);
      chk("stream_in_ready", 32'(ir4), 32'd1);
      chk("stream_out_valid", 32'(ov4), (c >= 4 && c < 20) ? 32'd1 : 32'd0);
      if (c >= 4 && c < 20) chk("stream_dout", 32'(dout4), 32'(c - 3));
      chk("stream_count", 32'(cnt4), (c < 4) ? 32'(c) : (c <= 16) ? 32'd4 : (c < 20) ? 32'(20 - c) : 32'd0);
      tick();
    end
    iv4 = 1'b0;

    // Backpressure fill
    or4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      iv4  = 1'b1;
      din4 = 8'(8'h20 + c);
      @(negedge clk);
      chk("fill_in_ready", 32'(ir4), (c < 4) ? 32'd1 : 32'd0);
      chk("fill_count", 32'(cnt4), (c < 4) ? 32'(c) : 32'd4);
      tick();
    end
    or4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iv4  = 1'b1;
      din4 = 8'(8'h30 + k);
      @(negedge clk);
      chk("full_in_ready", 32'(ir4), 32'd1);
      chk("full_count", 32'(cnt4), 32'd4);
      chk("full_out_valid", 32'(ov4), 32'd1);
      chk("full_dout", 32'(dout4), 32'(8'h20 + k));
      tick();
    end
    iv4 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("drain_dout", 32'(dout4), 32'(8'h30 + j));
      chk("drain_out_valid", 32'(ov4), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("drain_empty_valid", 32'(ov4), 32'd0);
    chk("drain_empty_count", 32'(cnt4), 32'd0);
    tick();

    // Bubble collapse: two beats with a 2-cycle gap, output stalled
    or4 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      iv4  = (c == 0 || c == 3);
      din4 = (c == 0) ? 8'h41 : 8'h42;
      tick();
    end
    iv4 = 1'b0;
    @(negedge clk);
    chk("bubble_count", 32'(cnt4), 32'd2);
    chk("bubble_out_valid", 32'(ov4), 32'd1);
    chk("bubble_in_ready", 32'(ir4), 32'd1);
    tick();
    or4 = 1'b1;
    @(negedge clk);
    chk("bubble_first", 32'(dout4), 32'h41);
    tick();
    @(negedge clk);
    chk("bubble_second_valid", 32'(ov4), 32'd1);
    chk("bubble_second", 32'(dout4), 32'h42);
    tick();
    @(negedge clk);
    chk("bubble_done_valid", 32'(ov4), 32'd0);
    tick();

    // Flush with count=3 while a new beat is offered
    or4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      iv4  = 1'b1;
      din4 = 8'(8'h51 + c);
      tick();
    end
    flush4 = 1'b1;
    iv4    = 1'b1;
    din4   = 8'h5F;
    @(negedge clk);
    chk("flush_pre_count", 32'(cnt4), 32'd3);
    chk("flush_in_ready", 32'(ir4), 32'd0);
    tick();
    flush4 = 1'b0;
    iv4    = 1'b0;
    or4    = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(ov4), 32'd0);
      chk("flush_count", 32'(cnt4), 32'd0);
      tick();
    end

    // Reset mid-stream with a full pipe
    or4 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      iv4  = 1'b1;
      din4 = 8'(8'h61 + c);
      tick();
    end
    iv4 = 1'b0;
    @(negedge clk);
    chk("prerst_count", 32'(cnt4), 32'd4);
    tick();
    rst  = 1'b1;
    iv4  = 1'b1;
    din4 = 8'h77;
    @(negedge clk);
    chk("midrst_in_ready", 32'(ir4), 32'd0);
    tick();
    rst = 1'b0;
    iv4 = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(ov4), 32'd0);
    chk("midrst_dout", 32'(dout4), 32'd0);
    chk("midrst_count", 32'(cnt4), 32'd0);
    chk("midrst_in_ready_after", 32'(ir4), 32'd1);
    tick();

    // LATENCY=1 random traffic against a queue scoreboard
    for (int c = 0; c < 300; c++) begin
      iv1  = (c < 290) ? 1'($urandom_range(0, 1)) : 1'b0;
      or1  = (c < 290) ? 1'($urandom_range(0, 1)) : 1'b1;
      din1 = $urandom;
      @(negedge clk);
      chk("l1_out_valid", 32'(ov1), (sb_q.size() != 0) ? 32'd1 : 32'd0);
      chk("l1_count", 32'(cnt1), 32'(sb_q.size()));
      chk("l1_in_ready", 32'(ir1), (sb_q.size() == 0 || or1) ? 32'd1 : 32'd0);
      if (ov1 && or1) begin
        if (sb_q.size() != 0) begin
          chk("l1_dout", dout1, sb_q[0]);
          void'(sb_q.pop_front());
        end else begin
          chk("l1_spurious", 32'(ov1), 32'd0);
        end
      end
      if (iv1 && ir1) sb_q.push_back(din1);
      tick();
    end
    chk("l1_no_loss", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
